fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Multi-cycle instruction-fetch controller for the single-issue RISC-V core. It owns the program counter and sequences one request/response transaction at a time against instruction memory. It holds each fetched instruction until decode accepts it and applies branch redirects, including discarding an in-flight response for a stale PC. It replaces the free-running PC register as the front end of the datapath.

## Interface
- WORD_BITWIDTH, 32, width of PC, addresses and instruction words
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- branch_taken  in  1  redirect request, single-cycle pulse from execute
- branch_target  in  WORD_BITWIDTH  redirect byte address; bits [1:0] ignored, treated as 0
- id_ready  in  1  decode accepts the held instruction this cycle
- imem_req  out  1  fetch request valid
- imem_addr  out  WORD_BITWIDTH  fetch byte address
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response valid; never asserted in the same cycle as the matching imem_gnt
- imem_rdata  in  WORD_BITWIDTH  instruction word
- inst_valid  out  1  held instruction valid to decode
- inst  out  WORD_BITWIDTH  held instruction
- inst_pc  out  WORD_BITWIDTH  address of the held instruction
- pc  out  WORD_BITWIDTH  address of the next or in-flight fetch

## Operation
- States: REQ, WAIT, HOLD. Internal kill flag marks the outstanding response as stale.
- REQ: imem_req=1, imem_addr=pc. On imem_gnt, go to WAIT.
- WAIT: imem_req=0. On imem_rvalid with kill=0: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, go to HOLD. On imem_rvalid with kill=1: drop the data, clear kill, go to REQ.
- HOLD: inst_valid=1. On id_ready, go to REQ. inst and inst_pc stay stable while inst_valid=1 and id_ready=0.
- pc+4 wraps modulo 2^WORD_BITWIDTH.
- Redirect (branch_taken=1) has priority over id_ready and over normal PC update. It always sets pc<=branch_target with [1:0] forced to 0. Per state:
  - REQ without gnt: stay in REQ; the new address is presented next cycle.
  - REQ with gnt in the same cycle: go to WAIT with kill=1.
  - WAIT without rvalid: set kill=1.
  - WAIT with rvalid in the same cycle: discard the response, go to REQ.
  - HOLD: drop the held instruction (inst_valid falls next cycle), go to REQ.
- Only one transaction is ever outstanding.

## Timing
- Reset values: state=REQ, pc=RESET_PC, kill=0, inst_valid=0, inst=0, inst_pc=0. imem_req=0 while rst=1, and 1 in the first cycle after rst falls.
- imem_req and imem_addr are decoded from registered state and pc only; no combinational path from any input.
- inst_valid, inst and inst_pc are registered.
- Minimum latency: gnt at cycle N, rvalid at N+1, inst_valid at N+2.
- Peak throughput: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect to first fetch of the target: imem_addr=target one cycle after branch_taken when no transaction is in flight. Otherwise the request is issued in the cycle after the stale response arrives.
- rst asserted mid-transaction: return to the reset state; a later imem_rvalid for the aborted request is assumed not to occur (memory is reset together with the core).

## Structure
- Shared package fetch_pkg:
  - state enum {REQ, WAIT, HOLD}
  - INST_BYTES=4
  - RESET_PC default
- One sub-module, next_pc_sel: chooses between pc+INST_BYTES and the aligned branch_target from branch_taken; used by the PC register update.
- The FSM, kill flag and instruction hold register live in fetch_ctrl.

## Test plan
- Reset, then gnt in the first REQ cycle and rvalid one cycle later with rdata=32'h0000_0013 -> inst_valid two cycles after gnt, inst=32'h13, inst_pc=0, pc=4.
- id_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, no imem_req. id_ready=1 -> imem_req with imem_addr=4 the next cycle.
- branch_taken with target 32'h0000_0103 while in WAIT, response rdata=32'hDEAD_BEEF 3 cycles later -> response discarded, inst_valid stays 0, next imem_addr=32'h100.
- branch_taken and imem_gnt in the same REQ cycle at pc=8, target 32'h40 -> the following response is discarded, next imem_addr=32'h40.
- branch_taken and id_ready together in HOLD -> held instruction dropped, next fetch at the target. pc=32'hFFFF_FFFC fetch -> pc wraps to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +-- fetch_pkg: shared types and constants for the instruction-fetch front end (rev 1.0)
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +-- fetch_if: instruction-memory request/response channel (rev 1.0)
interface fetch_if #(
  parameter int WORD_BITWIDTH = 32
);

  logic                     imem_req;
  logic [WORD_BITWIDTH-1:0] imem_addr;
  logic                     imem_gnt;
  logic                     imem_rvalid;
  logic [WORD_BITWIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/fetch_next_pc_sel.sv
`default_nettype none
// +-- next_pc_sel: sequential successor or word-aligned redirect target (rev 1.0)
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32
) (
  input  wire logic [WORD_BITWIDTH-1:0] pc,
  input  wire logic                     branch_taken,
  input  wire logic [WORD_BITWIDTH-1:0] branch_target,
  output logic      [WORD_BITWIDTH-1:0] next_pc
);

  localparam logic [WORD_BITWIDTH-1:0] ALIGN_MASK = ~WORD_BITWIDTH'(INST_BYTES - 1);
  localparam logic [WORD_BITWIDTH-1:0] STEP       = WORD_BITWIDTH'(INST_BYTES);

  // Addition wraps naturally at the top of the address space.
  assign next_pc = branch_taken ? (branch_target & ALIGN_MASK) : (pc + STEP);

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +-- fetch_ctrl: PC owner, one-outstanding fetch sequencer and decode hold register (rev 1.0)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                       WORD_BITWIDTH = 32,
  parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = WORD_BITWIDTH'(RESET_PC_DEFAULT)
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     branch_taken,
  input  wire logic [WORD_BITWIDTH-1:0] branch_target,
  input  wire logic                     id_ready,
  fetch_if.master                       imem,
  output logic                          inst_valid,
  output logic      [WORD_BITWIDTH-1:0] inst,
  output logic      [WORD_BITWIDTH-1:0] inst_pc,
  output logic      [WORD_BITWIDTH-1:0] pc
);

  fetch_state_t             state, state_next;
  logic                     kill, kill_next;
  logic                     valid_next;
  logic [WORD_BITWIDTH-1:0] inst_next, inst_pc_next, pc_next;
  logic                     pc_load;

  next_pc_sel #(.WORD_BITWIDTH(WORD_BITWIDTH)) u_next_pc_sel (
    .pc           (pc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .next_pc      (pc_next)
  );

  always_comb begin
    state_next   = state;
    kill_next    = kill;
    valid_next   = inst_valid;
    inst_next    = inst;
    inst_pc_next = inst_pc;
    pc_load      = branch_taken;
    case (state)
      REQ: begin
        // A redirect coinciding with the grant leaves a stale response to absorb.
        if (imem.imem_gnt) begin
          state_next = WAIT;
          kill_next  = branch_taken;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          kill_next = 1'b0;
          if (kill || branch_taken) begin
            state_next = REQ;
          end else begin
            state_next   = HOLD;
            valid_next   = 1'b1;
            inst_next    = imem.imem_rdata;
            inst_pc_next = pc;
            pc_load      = 1'b1;
          end
        end else if (branch_taken) begin
          kill_next = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken || id_ready) begin
          state_next = REQ;
          valid_next = 1'b0;
        end
      end
      default: begin
        state_next = REQ;
        kill_next  = 1'b0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      kill       <= 1'b0;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_next;
      kill       <= kill_next;
      inst_valid <= valid_next;
      inst       <= inst_next;
      inst_pc    <= inst_pc_next;
      if (pc_load) pc <= pc_next;
    end
  end

  assign imem.imem_req  = (state == REQ) && !rst;
  assign imem.imem_addr = pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +-- tb_fetch_ctrl: directed vector table, corner sequence and randomized model check (rev 1.0)
module tb_fetch_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         branch_taken;
  logic [W-1:0] branch_target;
  logic         id_ready;
  logic         inst_valid;
  logic [W-1:0] inst, inst_pc, pc;

  fetch_if #(.WORD_BITWIDTH(W)) imem ();

  fetch_ctrl #(.WORD_BITWIDTH(W), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .id_ready     (id_ready),
    .imem         (imem),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .pc           (pc)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(logic r, logic g, logic v, logic [W-1:0] d,
                       logic b, logic [W-1:0] t, logic y);
    rst              = r;
    imem.imem_gnt    = g;
    imem.imem_rvalid = v;
    imem.imem_rdata  = d;
    branch_taken     = b;
    branch_target    = t;
    id_ready         = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rst, gnt, rv;
    logic [W-1:0] rd;
    logic         br;
    logic [W-1:0] tg;
    logic         rdy;
    logic         e_req;
    logic [W-1:0] e_pc;
    logic         e_valid;
    logic         ci;
    logic [W-1:0] e_inst, e_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic g, logic v, logic [W-1:0] d, logic b,
                              logic [W-1:0] t, logic y, logic er, logic [W-1:0] ep,
                              logic ev, logic ci, logic [W-1:0] ei, logic [W-1:0] eip);
    vec_t x;
    x.rst = r; x.gnt = g; x.rv = v; x.rd = d; x.br = b; x.tg = t; x.rdy = y;
    x.e_req = er; x.e_pc = ep; x.e_valid = ev; x.ci = ci; x.e_inst = ei; x.e_ipc = eip;
    tbl.push_back(x);
  endfunction

  // Reference model: one transaction in flight, a stale marker, and a one-entry hold slot.
  logic [W-1:0] m_pc, m_hinst, m_hpc;
  logic         m_out, m_stale, m_held;

  function automatic void model_reset();
    m_pc = '0; m_out = 0; m_stale = 0; m_held = 0; m_hinst = '0; m_hpc = '0;
  endfunction

  function automatic void model_step(logic g, logic v, logic [W-1:0] d, logic b,
                                     logic [W-1:0] t, logic y);
    if (!m_out && !m_held) begin
      if (g) begin m_out = 1; m_stale = b; end
    end else if (m_out) begin
      if (v) begin
        m_out = 0;
        if (!m_stale && !b) begin
          m_held = 1; m_hinst = d; m_hpc = m_pc; m_pc = m_pc + 32'd4;
        end
        m_stale = 0;
      end else if (b) begin
        m_stale = 1;
      end
    end else if (b || y) begin
      m_held = 0;
    end
    if (b) m_pc = {t[W-1:2], 2'b00};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1);
  end

  initial begin
    logic         req_m, g, v, b, y;
    logic [W-1:0] d, t;
    int           n;

    drive(1, 0, 0, '0, 0, '0, 0);

    //   rst g v rdata          br target         rdy | req pc            vld ci inst           inst_pc
    add(1, 0, 0, 32'h0,          0, 32'h0,         0,  0, 32'h0,          0,  1, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,          0, 32'h0,         0,  0, 32'h0,          0,  1, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,         0,  0, 32'h0,          0,  0, 32'h0,         32'h0);
    add(0, 0, 1, 32'h13,         0, 32'h0,         0,  0, 32'h4,          1,  1, 32'h13,        32'h0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 0, 32'h0,        0, 32'h0,         0,  0, 32'h4,          1,  1, 32'h13,        32'h0);
    add(0, 0, 0, 32'h0,          0, 32'h0,         1,  1, 32'h4,          0,  0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,         0,  0, 32'h4,          0,  0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,          1, 32'h103,       0,  0, 32'h100,        0,  0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,          0, 32'h0,         0,  0, 32'h100,        0,  0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,          0, 32'h0,         0,  0, 32'h100,        0,  0, 32'h0,         32'h0);
    add(0, 0, 1, 32'hDEAD_BEEF,  0, 32'h0,         0,  1, 32'h100,        0,  0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,         0,  0, 32'h100,        0,  0, 32'h0,         32'h0);
    add(0, 0, 1, 32'h1111_1111,  0, 32'h0,         0,  0, 32'h104,        1,  1, 32'h1111_1111, 32'h100);
    add(0, 0, 0, 32'h0,          1, 32'h8,         1,  1, 32'h8,          0,  0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,          1, 32'h40,        0,  0, 32'h40,         0,  0, 32'h0,         32'h0);
    add(0, 0, 1, 32'hAAAA_AAAA,  0, 32'h0,         0,  1, 32'h40,         0,  0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,         0,  0, 32'h40,         0,  0, 32'h0,         32'h0);
    add(0, 0, 1, 32'h33,         0, 32'h0,         0,  0, 32'h44,         1,  1, 32'h33,        32'h40);
    add(0, 0, 0, 32'h0,          1, 32'hFFFF_FFFF, 1,  1, 32'hFFFF_FFFC,  0,  0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,         0,  0, 32'hFFFF_FFFC,  0,  0, 32'h0,         32'h0);
    add(0, 0, 1, 32'h44,         0, 32'h0,         0,  0, 32'h0,          1,  1, 32'h44,        32'hFFFF_FFFC);
    add(0, 0, 0, 32'h0,          0, 32'h0,         1,  1, 32'h0,          0,  0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,         0,  0, 32'h0,          0,  0, 32'h0,         32'h0);
    add(0, 0, 1, 32'h55,         1, 32'h200,       0,  1, 32'h200,        0,  0, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,          1, 32'h300,       0,  1, 32'h300,        0,  0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,          0, 32'h0,         0,  0, 32'h300,        0,  0, 32'h0,         32'h0);
    add(1, 0, 0, 32'h0,          0, 32'h0,         0,  0, 32'h0,          0,  1, 32'h0,         32'h0);
    add(0, 0, 0, 32'h0,          0, 32'h0,         0,  1, 32'h0,          0,  1, 32'h0,         32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].gnt, tbl[i].rv, tbl[i].rd, tbl[i].br, tbl[i].tg, tbl[i].rdy);
      tick();
      chk($sformatf("vec%0d imem_req", i), W'(imem.imem_req), W'(tbl[i].e_req));
      chk($sformatf("vec%0d imem_addr", i), imem.imem_addr, tbl[i].e_pc);
      chk($sformatf("vec%0d pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d inst_valid", i), W'(inst_valid), W'(tbl[i].e_valid));
      if (tbl[i].ci) begin
        chk($sformatf("vec%0d inst", i), inst, tbl[i].e_inst);
        chk($sformatf("vec%0d inst_pc", i), inst_pc, tbl[i].e_ipc);
      end
    end

    // Slow memory response, then reset while the instruction is held.
    drive(1, 0, 0, '0, 0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 0, '0, 0);
    n = 0;
    while (!imem.imem_req && n < 5) begin tick(); n++; end
    chk("seq req_within_bound", W'(imem.imem_req), W'(1));
    drive(0, 1, 0, '0, 0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 0, '0, 0);
    repeat (4) tick();
    chk("seq no_valid_while_waiting", W'(inst_valid), W'(0));
    drive(0, 0, 1, 32'h77, 0, '0, 0);
    tick();
    drive(0, 0, 0, '0, 0, '0, 0);
    n = 0;
    while (!inst_valid && n < 10) begin tick(); n++; end
    chk("seq valid_within_bound", W'(inst_valid), W'(1));
    chk("seq inst", inst, 32'h77);
    chk("seq inst_pc", inst_pc, 32'h0);
    drive(1, 0, 0, '0, 0, '0, 0);
    tick();
    chk("seq rst valid", W'(inst_valid), W'(0));
    chk("seq rst inst", inst, 32'h0);
    chk("seq rst pc", pc, 32'h0);

    // Randomized run against the reference model.
    drive(0, 0, 0, '0, 0, '0, 0);
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      req_m = !m_out && !m_held;
      g = req_m && ($urandom_range(0, 1) == 1);
      v = m_out && ($urandom_range(0, 2) == 0);
      d = $urandom;
      b = ($urandom_range(0, 7) == 0);
      t = $urandom;
      y = ($urandom_range(0, 1) == 1);
      drive(0, g, v, d, b, t, y);
      model_step(g, v, d, b, t, y);
      tick();
      chk($sformatf("rnd%0d imem_req", c), W'(imem.imem_req), W'(!m_out && !m_held));
      chk($sformatf("rnd%0d pc", c), pc, m_pc);
      chk($sformatf("rnd%0d imem_addr", c), imem.imem_addr, m_pc);
      chk($sformatf("rnd%0d inst_valid", c), W'(inst_valid), W'(m_held));
      if (m_held) begin
        chk($sformatf("rnd%0d inst", c), inst, m_hinst);
        chk($sformatf("rnd%0d inst_pc", c), inst_pc, m_hpc);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
